mem_hit_responder: RTL

// - Memory-side responder for the control unit's request handshake. It takes

---
 rtl/mem_hit_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_hit_responder.sv
// mem_hit_responder
// Memory-side responder for the control unit's request handshake. It arbitrates
// one single-port RAM between instruction and data requests. Data requests have
// priority: write first, then read, then instruction. Every access gets LAT wait
// states, so the datapath stall paths are exercised.
//
// Ports
//   CLK, RST            clock and synchronous active-high reset
//   halt                blocks new instruction grants; an access already in
//                       flight still completes
//   iREN, iaddr         instruction read request; held until ihit
//   dREN, dWEN, daddr,  data read/write request; held until dhit
//   dstore
//   ihit, dhit          one-cycle completion pulses
//   iload, dload        last fetched instruction / loaded data word
//   ramREN, ramWEN,     RAM command, address and write data
//   ramaddr, ramstore
//   ramload, ram_ready  RAM read data and completion qualifier
//   req_err             sticky flag: dREN and dWEN were high together
module mem_hit_responder #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          halt,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          ihit,
  output logic          dhit,
  output logic [DW-1:0] iload,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload,
  input  logic          ram_ready,
  output logic          req_err
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_I = 2'd1, SEL_DR = 2'd2, SEL_DW = 2'd3} sel_t;

  state_t        state_q, state_d;
  sel_t          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ramaddr_q, ramaddr_d;
  logic [DW-1:0] ramstore_q, ramstore_d;
  logic [DW-1:0] iload_q, iload_d;
  logic [DW-1:0] dload_q, dload_d;
  logic          req_err_q, req_err_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;
  logic          ramREN_q, ramREN_d;
  logic          ramWEN_q, ramWEN_d;
  logic          req_live_s;

  // Is the request that owns the current grant still being held?
  always_comb begin
    req_live_s = 1'b0;
    case (sel_q)
      SEL_I:   req_live_s = iREN;
      SEL_DR:  req_live_s = dREN;
      SEL_DW:  req_live_s = dWEN;
      default: req_live_s = 1'b0;
    endcase
  end

  // Next-state logic: arbitration, wait-state counting, capture and abort.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    req_err_d  = req_err_q;
    case (state_q)
      IDLE: begin
        // A simultaneous read+write is served as a write and flagged.
        if (dWEN) begin
          sel_d      = SEL_DW;
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          cnt_d      = CW'(LAT - 1);
          state_d    = BUSY;
          if (dREN) begin
            req_err_d = 1'b1;
          end else begin
            req_err_d = req_err_q;
          end
        end else if (dREN) begin
          sel_d     = SEL_DR;
          ramaddr_d = daddr;
          cnt_d     = CW'(LAT - 1);
          state_d   = BUSY;
        end else if (iREN && !halt) begin
          sel_d     = SEL_I;
          ramaddr_d = iaddr;
          cnt_d     = CW'(LAT - 1);
          state_d   = BUSY;
        end else begin
          sel_d   = SEL_NONE;
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Abort takes precedence over completion: no hit, no load update.
        if (!req_live_s) begin
          sel_d   = SEL_NONE;
          state_d = IDLE;
        end else if (cnt_q != CW'(0)) begin
          cnt_d = cnt_q - CW'(1);
        end else if (ram_ready) begin
          if (sel_q == SEL_I) begin
            iload_d = ramload;
          end else if (sel_q == SEL_DR) begin
            dload_d = ramload;
          end else begin
            dload_d = dload_q;
          end
          state_d = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        sel_d   = SEL_NONE;
        state_d = IDLE;
      end
      default: begin
        sel_d   = SEL_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned
  // with the state they belong to.
  always_comb begin
    ramREN_d = (state_d == BUSY) && ((sel_d == SEL_I) || (sel_d == SEL_DR));
    ramWEN_d = (state_d == BUSY) && (sel_d == SEL_DW);
    ihit_d   = (state_d == RESP) && (sel_d == SEL_I);
    dhit_d   = (state_d == RESP) && ((sel_d == SEL_DR) || (sel_d == SEL_DW));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      sel_q      <= SEL_NONE;
      cnt_q      <= '0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      iload_q    <= '0;
      dload_q    <= '0;
      req_err_q  <= 1'b0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      req_err_q  <= req_err_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      ramREN_q   <= ramREN_d;
      ramWEN_q   <= ramWEN_d;
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign req_err  = req_err_q;

endmodule
